// File: rtl/vector_floating_point_fma_sequencer.sv
// Issue/retire sequencer for the vector FMA unit: decodes micro-ops, tracks them
// through the unit's fixed latency and buffers results in an in-order, credit-guarded FIFO.
module vector_floating_point_fma_sequencer #(
    parameter int VLEN       = 128,
    parameter int LATENCY    = 9,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [2:0]        issue_op_i,
    input  logic [1:0]        issue_vsew_i,
    input  logic [TAG_W-1:0]  issue_tag_i,
    input  logic [VLEN-1:0]   vs2_i,
    input  logic [VLEN-1:0]   vs1_i,
    input  logic [VLEN-1:0]   vd_old_i,
    output logic              fma_request_o,
    output logic [1:0]        fma_vsew_o,
    output logic              fma_negate_product_o,
    output logic              fma_multiplication_addition_subtraction_o,
    output logic              fma_overwrite_addend_multiplicand_o,
    output logic [VLEN-1:0]   fma_vs2_o,
    output logic [VLEN-1:0]   fma_vs1_o,
    output logic [VLEN-1:0]   fma_vd_old_o,
    input  logic [VLEN-1:0]   fma_vd_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [TAG_W-1:0]  result_tag_o,
    output logic [VLEN-1:0]   result_vd_o,
    output logic              result_error_o,
    input  logic              flush_i,
    output logic              busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CW-1:0]    credit_count;
    logic [CW-1:0]    fifo_count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             accept;
    logic             push;
    logic             pop;
    logic [2:0]       cfg;

    logic [LATENCY-1:0] trk_valid;
    logic [LATENCY-1:0] trk_err;
    logic [TAG_W-1:0]   trk_tag [LATENCY];

    logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
    logic [VLEN-1:0]  mem_vd  [FIFO_DEPTH];
    logic             mem_err [FIFO_DEPTH];

    function automatic logic [PW-1:0] ptr_incr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover every accepted op until it is popped, so the FIFO can never overflow.
    assign issue_ready_o = !flush_i && (credit_count < CW'(FIFO_DEPTH));
    assign accept        = issue_valid_i && issue_ready_o;
    assign fma_request_o = accept && issue_vsew_i[1];
    assign busy_o        = credit_count != '0;

    always_comb begin
        cfg = 3'b000;
        case (issue_op_i)
            3'd0: cfg = 3'b000;
            3'd1: cfg = 3'b110;
            3'd2: cfg = 3'b010;
            3'd3: cfg = 3'b100;
            3'd4: cfg = 3'b001;
            3'd5: cfg = 3'b111;
            3'd6: cfg = 3'b011;
            3'd7: cfg = 3'b101;
            default: cfg = 3'b000;
        endcase
    end

    assign {fma_negate_product_o, fma_multiplication_addition_subtraction_o,
            fma_overwrite_addend_multiplicand_o} = fma_request_o ? cfg : 3'b000;
    assign fma_vsew_o   = fma_request_o ? issue_vsew_i : 2'b00;
    assign fma_vs2_o    = fma_request_o ? vs2_i : '0;
    assign fma_vs1_o    = fma_request_o ? vs1_i : '0;
    assign fma_vd_old_o = fma_request_o ? vd_old_i : '0;

    // Unsupported-SEW ops ride the tracker too, so they retire in accept order.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            trk_valid <= '0;
            trk_err   <= '0;
            for (int i = 0; i < LATENCY; i++) trk_tag[i] <= '0;
        end else begin
            trk_valid  <= flush_i ? '0 : {trk_valid[LATENCY-2:0], accept};
            trk_err    <= {trk_err[LATENCY-2:0], !issue_vsew_i[1]};
            trk_tag[0] <= issue_tag_i;
            for (int i = 1; i < LATENCY; i++) trk_tag[i] <= trk_tag[i-1];
        end
    end

    assign push = trk_valid[LATENCY-1];
    assign pop  = result_valid_o && result_ready_i;

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_tag[wr_ptr] <= trk_tag[LATENCY-1];
            mem_vd[wr_ptr]  <= trk_err[LATENCY-1] ? '0 : fma_vd_i;
            mem_err[wr_ptr] <= trk_err[LATENCY-1];
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            credit_count <= '0;
        end else if (flush_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            credit_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_incr(wr_ptr);
            if (pop)  rd_ptr <= ptr_incr(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({accept, pop})
                2'b10:   credit_count <= credit_count + CW'(1);
                2'b01:   credit_count <= credit_count - CW'(1);
                default: credit_count <= credit_count;
            endcase
        end
    end

    assign result_valid_o = fifo_count != '0;
    assign result_tag_o   = result_valid_o ? mem_tag[rd_ptr] : '0;
    assign result_vd_o    = result_valid_o ? mem_vd[rd_ptr]  : '0;
    assign result_error_o = result_valid_o ? mem_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_vector_floating_point_fma_sequencer.sv
// Directed bench for the FMA sequencer: a behavioural unit model with fixed latency
// feeds the DUT, and a scoreboard queue predicts every result, its order and its arrival cycle.
module tb_vector_floating_point_fma_sequencer;

    localparam int VLEN       = 128;
    localparam int LATENCY    = 9;
    localparam int TAG_W      = 5;
    localparam int FIFO_DEPTH = 4;

    logic              clock_i = 1'b0;
    logic              reset_ni;
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [2:0]        issue_op_i;
    logic [1:0]        issue_vsew_i;
    logic [TAG_W-1:0]  issue_tag_i;
    logic [VLEN-1:0]   vs2_i, vs1_i, vd_old_i;
    logic              fma_request_o;
    logic [1:0]        fma_vsew_o;
    logic              fma_negate_product_o;
    logic              fma_multiplication_addition_subtraction_o;
    logic              fma_overwrite_addend_multiplicand_o;
    logic [VLEN-1:0]   fma_vs2_o, fma_vs1_o, fma_vd_old_o;
    logic [VLEN-1:0]   fma_vd_i;
    logic              result_valid_o;
    logic              result_ready_i;
    logic [TAG_W-1:0]  result_tag_o;
    logic [VLEN-1:0]   result_vd_o;
    logic              result_error_o;
    logic              flush_i;
    logic              busy_o;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [VLEN-1:0]  vd;
        logic             err;
        int               due;
    } exp_t;

    exp_t            sb[$];
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    int              credit_m = 0;
    logic [VLEN-1:0] unit_pipe [LATENCY];

    vector_floating_point_fma_sequencer #(
        .VLEN(VLEN), .LATENCY(LATENCY), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_op_i(issue_op_i), .issue_vsew_i(issue_vsew_i), .issue_tag_i(issue_tag_i),
        .vs2_i(vs2_i), .vs1_i(vs1_i), .vd_old_i(vd_old_i),
        .fma_request_o(fma_request_o), .fma_vsew_o(fma_vsew_o),
        .fma_negate_product_o(fma_negate_product_o),
        .fma_multiplication_addition_subtraction_o(fma_multiplication_addition_subtraction_o),
        .fma_overwrite_addend_multiplicand_o(fma_overwrite_addend_multiplicand_o),
        .fma_vs2_o(fma_vs2_o), .fma_vs1_o(fma_vs1_o), .fma_vd_old_o(fma_vd_old_o),
        .fma_vd_i(fma_vd_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_tag_o(result_tag_o), .result_vd_o(result_vd_o),
        .result_error_o(result_error_o),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [2:0] cfg_table(input logic [2:0] op);
        case (op)
            3'd0: return 3'b000;
            3'd1: return 3'b110;
            3'd2: return 3'b010;
            3'd3: return 3'b100;
            3'd4: return 3'b001;
            3'd5: return 3'b111;
            3'd6: return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    // Stand-in for the arithmetic: any config/SEW/operand mix-up changes the result.
    function automatic logic [VLEN-1:0] unit_fn(input logic [2:0] cfg, input logic [1:0] sew,
                                                input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                                input logic [VLEN-1:0] c);
        return a ^ {b[VLEN-2:0], b[VLEN-1]} ^ ~c ^ {{(VLEN-5){1'b0}}, cfg, sew};
    endfunction

    always @(posedge clock_i) begin
        for (int i = LATENCY - 1; i > 0; i--) unit_pipe[i] <= unit_pipe[i-1];
        unit_pipe[0] <= fma_request_o
            ? unit_fn({fma_negate_product_o, fma_multiplication_addition_subtraction_o,
                       fma_overwrite_addend_multiplicand_o}, fma_vsew_o,
                      fma_vs2_o, fma_vs1_o, fma_vd_old_o)
            : {$urandom, $urandom, $urandom, $urandom};
    end
    assign fma_vd_i = unit_pipe[LATENCY-1];

    task automatic checkOutput(input string name, input logic [VLEN-1:0] obs,
                               input logic [VLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_issue_ready", issue_ready_o, 1);
        checkOutput("rst_fma_request", fma_request_o, 0);
        checkOutput("rst_fma_cfg", {fma_negate_product_o, fma_multiplication_addition_subtraction_o,
                                    fma_overwrite_addend_multiplicand_o}, 0);
        checkOutput("rst_fma_vsew", fma_vsew_o, 0);
        checkOutput("rst_fma_vs2", fma_vs2_o, 0);
        checkOutput("rst_result_valid", result_valid_o, 0);
        checkOutput("rst_result_tag", result_tag_o, 0);
        checkOutput("rst_result_vd", result_vd_o, 0);
        checkOutput("rst_result_error", result_error_o, 0);
        checkOutput("rst_busy", busy_o, 0);
    endtask

    // One clock cycle: entered just after a falling edge with inputs already driven.
    task automatic applyStimulus(output bit acc);
        logic       exp_ready, exp_req, exp_valid, pop;
        logic [2:0] cfg;
        int         in_fifo;
        #1;
        exp_ready = !flush_i && (credit_m < FIFO_DEPTH);
        acc       = issue_valid_i && exp_ready;
        exp_req   = acc && issue_vsew_i[1];
        cfg       = cfg_table(issue_op_i);
        checkOutput("issue_ready", issue_ready_o, exp_ready);
        checkOutput("busy", busy_o, credit_m != 0);
        checkOutput("fma_request", fma_request_o, exp_req);
        checkOutput("fma_cfg", {fma_negate_product_o, fma_multiplication_addition_subtraction_o,
                                fma_overwrite_addend_multiplicand_o}, exp_req ? cfg : 3'b000);
        checkOutput("fma_vsew", fma_vsew_o, exp_req ? issue_vsew_i : 2'b00);
        checkOutput("fma_vd_old", fma_vd_old_o, exp_req ? vd_old_i : '0);
        exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
        checkOutput("result_valid", result_valid_o, exp_valid);
        if (exp_valid) begin
            checkOutput("result_tag", result_tag_o, sb[0].tag);
            checkOutput("result_vd", result_vd_o, sb[0].vd);
            checkOutput("result_error", result_error_o, sb[0].err);
        end
        in_fifo = 0;
        foreach (sb[i]) if (sb[i].due <= cyc + 1) in_fifo++;
        pop = exp_valid && result_ready_i;
        checkOutput("fifo_no_overflow", in_fifo - (pop ? 1 : 0) <= FIFO_DEPTH, 1);
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back('{tag: issue_tag_i, err: !issue_vsew_i[1],
            vd: issue_vsew_i[1] ? unit_fn(cfg, issue_vsew_i, vs2_i, vs1_i, vd_old_i) : '0,
            due: cyc + LATENCY + 1});
        credit_m = credit_m + (acc ? 1 : 0) - (pop ? 1 : 0);
        if (flush_i) begin
            sb.delete();
            credit_m = 0;
        end
        @(posedge clock_i);
        cyc++;
        @(negedge clock_i);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(acc);
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] sew, input logic [TAG_W-1:0] tag,
                         input int bound, output bit acc);
        issue_valid_i = 1'b1;
        issue_op_i    = op;
        issue_vsew_i  = sew;
        issue_tag_i   = tag;
        vs2_i    = {$urandom, $urandom, $urandom, $urandom};
        vs1_i    = {$urandom, $urandom, $urandom, $urandom};
        vd_old_i = {$urandom, $urandom, $urandom, $urandom};
        acc = 1'b0;
        for (int n = 0; n < bound; n++) begin
            applyStimulus(acc);
            if (acc) break;
        end
        issue_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        reset_ni = 1'b0;
        issue_valid_i = 1'b0; issue_op_i = '0; issue_vsew_i = '0; issue_tag_i = '0;
        vs2_i = '0; vs1_i = '0; vd_old_i = '0;
        result_ready_i = 1'b1; flush_i = 1'b0;
        #3;
        checkResetValues();
        @(negedge clock_i);
        @(negedge clock_i);
        reset_ni = 1'b1;

        $display("[TB] single vfmacc SEW32");
        cyc = 0;
        issue_valid_i = 1'b1; issue_op_i = 3'd0; issue_vsew_i = 2'b10; issue_tag_i = 5'd3;
        vs2_i = {4{32'h40000000}}; vs1_i = {4{32'h40000000}}; vd_old_i = {4{32'h3F800000}};
        applyStimulus(acc);
        checkOutput("single_accept", acc, 1);
        issue_valid_i = 1'b0;
        idle(12);

        $display("[TB] eight ops back-to-back SEW64");
        for (int op = 0; op < 8; op++) begin
            issue(3'(op), 2'b11, 5'(8 + op), 30, acc);
            checkOutput("b2b_accept", acc, 1);
        end
        idle(20);

        $display("[TB] credit exhaustion with consumer stalled");
        result_ready_i = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            issue(3'(i), 2'b10, 5'(16 + i), 1, acc);
            n_acc += acc ? 1 : 0;
        end
        issue(3'd4, 2'b10, 5'd20, 14, acc);
        n_acc += acc ? 1 : 0;
        checkOutput("accepted_while_stalled", n_acc, 4);
        result_ready_i = 1'b1;
        issue(3'd4, 2'b10, 5'd20, 20, acc);
        checkOutput("accept_after_credit", acc, 1);
        issue(3'd5, 2'b10, 5'd21, 20, acc);
        checkOutput("accept_after_credit", acc, 1);
        idle(20);

        $display("[TB] unsupported SEW between supported ops");
        issue(3'd0, 2'b10, 5'd1, 5, acc);
        issue(3'd1, 2'b01, 5'd7, 5, acc);
        issue(3'd2, 2'b10, 5'd2, 5, acc);
        idle(15);

        $display("[TB] flush with work in flight and buffered");
        result_ready_i = 1'b0;
        issue(3'd0, 2'b10, 5'd9, 5, acc);
        idle(10);
        for (int i = 0; i < 3; i++) issue(3'(i + 1), 2'b11, 5'(10 + i), 5, acc);
        idle(2);
        flush_i = 1'b1;
        issue_valid_i = 1'b1; issue_vsew_i = 2'b10; issue_tag_i = 5'd31;
        applyStimulus(acc);
        flush_i = 1'b0;
        issue_valid_i = 1'b0;
        result_ready_i = 1'b1;
        applyStimulus(acc);
        issue(3'd4, 2'b10, 5'd22, 5, acc);
        idle(14);

        $display("[TB] asynchronous reset mid-operation");
        issue(3'd0, 2'b10, 5'd23, 5, acc);
        idle(4);
        #2;
        reset_ni = 1'b0;
        #1;
        checkResetValues();
        sb.delete();
        credit_m = 0;
        @(posedge clock_i);
        @(negedge clock_i);
        reset_ni = 1'b1;
        idle(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
